// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the PC, one outstanding imem read, small in-order instruction buffer.
// rvalid in N -> inst_valid in N+1; fetch requests are withheld while buffer plus in-flight would exceed BUF_DEPTH.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  Op,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  input  logic        redirect_valid,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm,
  input  logic [31:0] alu_out
);

  localparam int          AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DROP} state_t;

  state_t        r_state, w_state_nx;
  logic [31:0]   r_fetch_pc, w_pc_nx;
  logic          r_req, w_req_nx;
  logic [AW:0]   r_count, w_count_nx;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_nx, w_wr_ptr_nx;
  logic [31:0]   r_buf_pc  [BUF_DEPTH];
  logic [31:0]   r_buf_dat [BUF_DEPTH];

  logic          w_redirect, w_grant, w_pop, w_push, w_empty;
  logic [31:0]   w_sum, w_target;

  assign w_empty    = (r_count == '0);
  assign w_sum      = redirect_pc + redirect_imm;
  assign w_redirect = redirect_valid &&
                      (NPCOp == 3'b001 || NPCOp == 3'b010 || NPCOp == 3'b100);
  assign w_target   = (NPCOp == 3'b100) ? (alu_out & ~32'h3) : (w_sum & ~32'h3);
  assign w_grant    = r_req && imem_gnt;
  assign w_pop      = !w_empty && inst_ready;
  // A response that coincides with a redirect belongs to the old path and is dropped.
  assign w_push     = (r_state == S_WAIT) && imem_rvalid && !w_redirect;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_fetch_pc;
    case (r_state)
      S_IDLE: w_state_nx = S_FETCH;
      S_FETCH: begin
        if (w_redirect) begin
          w_pc_nx    = w_target;
          w_state_nx = w_grant ? S_DROP : S_FETCH;
        end else if (w_grant) begin
          w_pc_nx    = r_fetch_pc + 32'd4;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nx    = w_target;
          w_state_nx = imem_rvalid ? S_FETCH : S_DROP;
        end else if (imem_rvalid) begin
          w_state_nx = S_FETCH;
        end
      end
      S_DROP: begin
        if (w_redirect) w_pc_nx = w_target;
        if (imem_rvalid) w_state_nx = S_FETCH;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_ptr_nx = r_rd_ptr;
    w_wr_ptr_nx = r_wr_ptr;
    w_count_nx  = r_count;
    if (w_redirect) begin
      w_rd_ptr_nx = '0;
      w_wr_ptr_nx = '0;
      w_count_nx  = '0;
    end else begin
      if (w_pop)  w_rd_ptr_nx = r_rd_ptr + AW'(1);
      if (w_push) w_wr_ptr_nx = r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nx = r_count + (AW+1)'(1);
        2'b01:   w_count_nx = r_count - (AW+1)'(1);
        default: w_count_nx = r_count;
      endcase
    end
    // Request is registered from next-state so it never depends on this cycle's grant.
    w_req_nx = (w_state_nx == S_FETCH) && (w_count_nx < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_pc_nx;
      r_req      <= w_req_nx;
      r_count    <= w_count_nx;
      r_rd_ptr   <= w_rd_ptr_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]  <= r_fetch_pc - 32'd4;
      r_buf_dat[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = !w_empty;
  assign inst       = w_empty ? NOP : r_buf_dat[r_rd_ptr];
  assign inst_pc    = w_empty ? 32'h0 : r_buf_pc[r_rd_ptr];
  assign Op         = inst[6:0];
  assign Funct3     = inst[14:12];
  assign Funct7     = inst[31:25];

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front-end for the RISC-V core. It owns the PC, issues word reads to instruction memory over a request/grant/response interface, and buffers returned words in a small FIFO. The buffered words drive `Op`, `Funct3` and `Funct7` into the control decoder. It also accepts the decoder's `NPCOp` redirect, flushes the buffer on a taken branch or jump, and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request; held with a stable address until granted.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid; in order, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: buffer head valid.
- `inst_ready` in 1: consumer takes the head this cycle.
- `inst` out 32: head instruction word.
- `inst_pc` out 32: head instruction address.
- `Op` out 7, `Funct3` out 3, `Funct7` out 7: `inst[6:0]`, `inst[14:12]`, `inst[31:25]`.
- `redirect_valid` in 1: an executing instruction presents `NPCOp` this cycle.
- `NPCOp` in 3: 000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR; any other code is treated as PLUS4.
- `redirect_pc` in 32: PC of the redirecting instruction.
- `redirect_imm` in 32: sign-extended branch/jal offset.
- `alu_out` in 32: jalr target sum.

## Operation
- **Redirect** = `redirect_valid` & (`NPCOp` ∈ {001, 010, 100}).
- **Target**:
  - BRANCH and JUMP: `redirect_pc + redirect_imm`.
  - JALR: `alu_out & ~1`.
  - In all cases bits [1:0] are forced to 00. Arithmetic is mod 2^32 and wraps silently.
- **State**: `fetch_pc` (32-bit), `buf` (BUF_DEPTH × {pc, word}), `count`, and `outstanding` (0/1; at most one request in flight).
- **Credit**: `imem_req` = (state==FETCH) & (`count` + `outstanding` < BUF_DEPTH).
- **FSM** (reset state IDLE):
  - **IDLE**: go to FETCH on the next edge. `imem_req` = 0.
  - **FETCH**:
    - On `imem_req` & `imem_gnt`: `fetch_pc` += 4, go to WAIT.
    - On redirect without grant: `fetch_pc` ← target, flush `buf`, stay in FETCH.
    - On redirect with grant in the same cycle: `fetch_pc` ← target, flush, go to DROP.
  - **WAIT**:
    - On `imem_rvalid`: push {`fetch_pc`−4, `imem_rdata`}, go to FETCH.
    - On redirect: `fetch_pc` ← target, flush, go to DROP.
    - If `imem_rvalid` and redirect coincide: the word is discarded, go to FETCH.
  - **DROP**:
    - On `imem_rvalid`: discard the word, go to FETCH.
    - On a further redirect: update `fetch_pc`, stay in DROP.
- **Buffer**:
  - Pop on `inst_valid` & `inst_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push is never attempted when full; the credit rule guarantees this.
- **Redirect vs. pop**: redirect has priority over the buffer. A pop handshake in the redirect cycle still counts as consumed, and the buffer ends empty.
- **Empty buffer**: `inst` = 32'h0000_0013 (nop), `inst_pc` = 0, `inst_valid` = 0.
- **Reset values**: `imem_req` 0, `imem_addr` `RESET_PC`, `inst_valid` 0, `inst` 32'h0000_0013, `inst_pc` 0, `Op` 7'h13, `Funct3` 0, `Funct7` 0. Internally `count` 0, `outstanding` 0.
- **Reset mid-transaction**: all state clears immediately. A response arriving after `rstn` rises with no outstanding request is ignored.

## Timing
- `imem_addr` = `fetch_pc`, registered. `imem_req` is decoded from registered state only, with no combinational path from `imem_gnt`.
- First request is in the 2nd cycle after `rstn` deasserts (IDLE lasts one cycle).
- `imem_rvalid` in cycle N → `inst_valid` = 1 in cycle N+1. There is no bypass.
- Redirect in cycle N:
  - `inst_valid` = 0 in N+1.
  - `imem_req` to the target in N+1 if the state becomes FETCH.
  - Otherwise `imem_req` follows one cycle after the stale `imem_rvalid`.
- Throughput with single-cycle grant and response: one word per 2 cycles. This is the fixed cost of allowing only one outstanding request.
- All outputs change only on `clk` rising edges, or asynchronously on `rstn` assertion.

## Test plan
- **Reset/boot**: release `rstn`, memory grants immediately and returns 32'h00500093 one cycle later. `imem_addr` = 0 on the first req; `inst_valid` is 1 two cycles after the grant with `inst_pc` = 0, `Op` = 7'h13, `Funct3` = 0.
- **Backpressure**: hold `inst_ready` = 0 with BUF_DEPTH = 2. Exactly 2 words (PC 0, 4) are fetched, then `imem_req` stays 0. Raising `inst_ready` for 1 cycle yields the next req at addr 8.
- **Branch redirect**: `redirect_valid` = 1, `NPCOp` = 001, `redirect_pc` = 0x10, `redirect_imm` = 0xFFFF_FFF8. The buffer flushes, and the next req is at 0x08 with `inst_pc` = 0x08.
- **Stale drop**: issue a redirect while in WAIT with `NPCOp` = 100 and `alu_out` = 0x103. The response for the old PC is discarded, the next req is at 0x100, and no stale `inst_valid` appears.
- **Simultaneous events**: redirect together with a pop and an `imem_rvalid` in one cycle. `count` = 0 afterwards, no push, the state is FETCH, and `NPCOp` = 011 alone causes no redirect.
- **Mid-fetch reset**: assert `rstn` = 0 in WAIT, then send `imem_rvalid` after release. All outputs show reset values, the late response is ignored, and fetch restarts at `RESET_PC`.
